// File: rtl/rf_cmd_sequencer.sv
// rf_cmd_sequencer: serialises CPU commands into single-cycle RF write strobes and returns one response per command
module rf_cmd_sequencer #(
    parameter int RF_ADDR_WIDTH = 2,
    parameter int RF_DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_funct,
    input  logic [RF_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [RF_DATA_WIDTH-1:0] cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RF_DATA_WIDTH-1:0] rsp_data,
    output logic [RF_ADDR_WIDTH-1:0] rf_addr,
    output logic                     rf_wren,
    output logic [RF_DATA_WIDTH-1:0] rf_data,
    input  logic [RF_DATA_WIDTH-1:0] rf0,
    input  logic [RF_DATA_WIDTH-1:0] rf1,
    input  logic [RF_DATA_WIDTH-1:0] rf2,
    input  logic [RF_DATA_WIDTH-1:0] rf3,
    output logic                     busy
);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, SEQ = 2'd2, RESP = 2'd3;
    logic [1:0] state, cnt;
    logic [RF_DATA_WIDTH-1:0] rd, cdat;
    logic is_wr, is_seq;
    assign cmd_ready = state == IDLE;
    assign busy      = !cmd_ready;
    assign rsp_valid = state == RESP;
    always_comb begin
        rd     = cmd_addr[1] ? (cmd_addr[0] ? rf3 : rf2) : (cmd_addr[0] ? rf1 : rf0);
        is_seq = cmd_funct == 3'd1 || cmd_funct == 3'd3;
        is_wr  = cmd_funct == 3'd0 || is_seq;
        cdat   = cmd_funct == 3'd3 ? '0 : cmd_data;
    end
    // rf_data doubles as the response payload for WRITE/BCAST/CLEAR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            rf_wren  <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    rf_wren  <= is_wr;
                    cnt      <= '0;
                    rsp_data <= cmd_funct == 3'd2 ? rd : '0;
                    state    <= cmd_funct == 3'd0 ? WRITE : is_seq ? SEQ : RESP;
                    if (is_wr) begin
                        rf_addr <= cmd_funct == 3'd0 ? cmd_addr : '0;
                        rf_data <= cdat;
                    end
                end
                WRITE: begin
                    rf_wren  <= 1'b0;
                    rsp_data <= rf_data;
                    state    <= RESP;
                end
                SEQ: if (cnt == 2'd3) begin
                    rf_wren  <= 1'b0;
                    cnt      <= '0;
                    rsp_data <= rf_data;
                    state    <= RESP;
                end else begin
                    cnt     <= cnt + 2'd1;
                    rf_addr <= RF_ADDR_WIDTH'(cnt + 2'd1);
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule
